mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory between instruction fetch (port I) and load/store (port D) of the riscv core.
//  Registered single-outstanding arbiter: grants one requester, drives memory, routes the response back.
//  D wins by default; a starvation guard forces an I grant after STARVE_MAX consecutive D grants with I pending.
//  A per-transaction timeout returns an error response when memory stalls.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width (DW/8 byte enables)
//  STARVE_MAX  4   consecutive D grants allowed while if_req_i is high (>=1)
//  TIMEOUT     64  cycles from m_req_o rise to abort (>=2); counter width $clog2(TIMEOUT+1)
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  if_req_i     in   1     fetch read request, held until if_gnt_o
//  if_addr_i    in   AW    fetch address
//  if_gnt_o     out  1     fetch request accepted (combinational, IDLE only)
//  if_rvalid_o  out  1     one-cycle fetch response pulse
//  if_rdata_o   out  DW    fetch read data, valid with if_rvalid_o
//  if_err_o     out  1     fetch timed out, valid with if_rvalid_o
//  d_req_i      in   1     load/store request, held until d_gnt_o
//  d_we_i       in   1     1=store 0=load
//  d_be_i       in   DW/8  byte enables (stores)
//  d_addr_i     in   AW    data address
//  d_wdata_i    in   DW    store data
//  d_gnt_o      out  1     data request accepted (combinational, IDLE only)
//  d_rvalid_o   out  1     one-cycle load data / store completion pulse
//  d_rdata_o    out  DW    load data (0 for stores)
//  d_err_o      out  1     data access timed out, valid with d_rvalid_o
//  m_req_o      out  1     memory request, held until m_gnt_i
//  m_we_o, m_be_o, m_addr_o, m_wdata_o  out  1/DW/8/AW/DW  registered command fields
//  m_gnt_i      in   1     memory accepts command
//  m_rvalid_i   in   1     memory completion; m_rdata_i valid
//  m_rdata_i    in   DW    memory read data
// BEHAVIOUR
//  - States: IDLE -> REQ -> WAIT -> RESP -> IDLE. Owner register {I,D}.
//  - Reset: state=IDLE, all outputs 0, starve_cnt=0, tmo_cnt=0; in-flight transaction is dropped.
//  - IDLE: winner = D if d_req_i && !(if_req_i && starve_cnt==STARVE_MAX), else I if if_req_i.
//    Winner's gnt_o is high this cycle. Command fields and owner are registered; next state = REQ.
//  - starve_cnt: +1 on a D grant while if_req_i=1 (saturates); cleared on an I grant or a D grant with if_req_i=0.
//  - REQ: m_req_o=1 with stable fields. m_gnt_i -> WAIT. m_gnt_i and m_rvalid_i in the same cycle -> RESP.
//  - WAIT: m_rvalid_i -> capture m_rdata_i (0 for stores), next state = RESP.
//  - RESP: owner's rvalid_o=1 for exactly one cycle with registered data; err_o=0; next state = IDLE.
//  - Latency: gnt at T, m_req_o at T+1; zero-wait memory (gnt T+1, rvalid T+2) gives rvalid_o at T+3.
//    No grants occur in REQ/WAIT/RESP.
//  - Timeout: tmo_cnt counts in REQ and WAIT and clears on leaving them. At tmo_cnt==TIMEOUT-1 without completion:
//    drop m_req_o, go to RESP with err_o=1 and rdata=0.
//    m_rvalid_i outside WAIT/REQ is ignored (late response discarded).
//  - Simultaneous I and D requests with starve_cnt<STARVE_MAX -> D. Both gnt_o are never high together.
//  - Requester drops req before its grant: no grant issued, no state change.
// STRUCTURE
//  - mem_arb_pkg: typedef enum logic[1:0] {ST_IDLE,ST_REQ,ST_WAIT,ST_RESP} arb_state_t;
//    typedef enum logic {OWN_I,OWN_D} arb_owner_t.
//  - One sub-module, arb_starve_guard: starve_cnt and the priority decision (inputs if_req, d_req; outputs sel_i, sel_d).
//  - The FSM, command registers and timeout counter stay in this module.
// TESTING
//  1. if_req_i=1, addr=0x100, memory m_gnt_i T+1, m_rvalid_i T+2, rdata=0xDEADBEEF
//     -> if_gnt_o@T, if_rvalid_o@T+3, rdata=0xDEADBEEF, err=0.
//  2. Both requests held high, STARVE_MAX=4, zero-wait memory -> grant order D,D,D,D,I,D,D,D,D,I.
//  3. d_we_i=1, be=4'b0011, wdata=0x1234 at addr 0x200
//     -> m_we_o=1, m_be_o=0011, m_wdata_o=0x1234 stable until m_gnt_i; d_rvalid_o pulse, d_rdata_o=0.
//  4. m_gnt_i never asserted, TIMEOUT=64 -> m_req_o falls after 64 cycles, d_rvalid_o=1 with d_err_o=1;
//     a later stray m_rvalid_i is ignored.
//  5. rst asserted during WAIT -> all outputs 0 immediately (async); after release, a new if_req_i is granted in the first IDLE cycle.
//  6. m_gnt_i and m_rvalid_i same cycle in REQ -> RESP next cycle, single rvalid_o pulse, no duplicate response.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared state and owner encodings for the instruction/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} arb_state_t;
   typedef enum logic {OWN_I, OWN_D} arb_owner_t;

endpackage

// File: rtl/arb_starve_guard.sv
// Priority decision between fetch and load/store: D wins unless fetch has waited through
// STARVE_MAX consecutive D grants.
module arb_starve_guard #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic if_req,
   input  logic d_req,
   output logic sel_i,
   output logic sel_d
);

   localparam int unsigned CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   logic [CW-1:0] starve_cnt;
   logic          starved;

   assign starved = if_req && (starve_cnt == CNT_MAX);
   assign sel_d   = d_req && !starved;
   assign sel_i   = if_req && !sel_d;

   // Only a D grant that leaves fetch waiting extends the run; any other grant ends it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (en && sel_d && if_req) begin
         if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
      end else if (en && (sel_d || sel_i)) begin
         starve_cnt <= '0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch (I) and
// load/store (D), with starvation guard and per-transaction timeout.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req_i,
   input  logic [AW-1:0]   if_addr_i,
   output logic            if_gnt_o,
   output logic            if_rvalid_o,
   output logic [DW-1:0]   if_rdata_o,
   output logic            if_err_o,
   input  logic            d_req_i,
   input  logic            d_we_i,
   input  logic [DW/8-1:0] d_be_i,
   input  logic [AW-1:0]   d_addr_i,
   input  logic [DW-1:0]   d_wdata_i,
   output logic            d_gnt_o,
   output logic            d_rvalid_o,
   output logic [DW-1:0]   d_rdata_o,
   output logic            d_err_o,
   output logic            m_req_o,
   output logic            m_we_o,
   output logic [DW/8-1:0] m_be_o,
   output logic [AW-1:0]   m_addr_o,
   output logic [DW-1:0]   m_wdata_o,
   input  logic            m_gnt_i,
   input  logic            m_rvalid_i,
   input  logic [DW-1:0]   m_rdata_i
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   arb_state_t    state;
   arb_owner_t    owner;
   logic [TW-1:0] tmo_cnt;
   logic [DW-1:0] rdata_q;
   logic          sel_i;
   logic          sel_d;
   logic          idle;
   logic          done;

   // Grants are gated by rst so every output reads 0 while reset is held.
   assign idle = (state == ST_IDLE) && !rst;

   arb_starve_guard #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve_guard (
      .clk   (clk),
      .rst   (rst),
      .en    (idle),
      .if_req(if_req_i),
      .d_req (d_req_i),
      .sel_i (sel_i),
      .sel_d (sel_d)
   );

   assign if_gnt_o   = idle && sel_i;
   assign d_gnt_o    = idle && sel_d;
   assign if_rdata_o = rdata_q;
   assign d_rdata_o  = rdata_q;

   // A response counts only while the command is live; in REQ it needs the grant alongside.
   assign done = m_rvalid_i && ((state == ST_WAIT) || (state == ST_REQ && m_gnt_i));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         owner       <= OWN_I;
         tmo_cnt     <= '0;
         rdata_q     <= '0;
         m_req_o     <= 1'b0;
         m_we_o      <= 1'b0;
         m_be_o      <= '0;
         m_addr_o    <= '0;
         m_wdata_o   <= '0;
         if_rvalid_o <= 1'b0;
         d_rvalid_o  <= 1'b0;
         if_err_o    <= 1'b0;
         d_err_o     <= 1'b0;
      end else begin
         if_rvalid_o <= 1'b0;
         d_rvalid_o  <= 1'b0;
         if_err_o    <= 1'b0;
         d_err_o     <= 1'b0;
         case (state)
            ST_IDLE: begin
               tmo_cnt <= '0;
               if (sel_d) begin
                  owner     <= OWN_D;
                  m_req_o   <= 1'b1;
                  m_we_o    <= d_we_i;
                  m_be_o    <= d_be_i;
                  m_addr_o  <= d_addr_i;
                  m_wdata_o <= d_wdata_i;
                  state     <= ST_REQ;
               end else if (sel_i) begin
                  owner     <= OWN_I;
                  m_req_o   <= 1'b1;
                  m_we_o    <= 1'b0;
                  m_be_o    <= '1;
                  m_addr_o  <= if_addr_i;
                  m_wdata_o <= '0;
                  state     <= ST_REQ;
               end
            end
            ST_REQ, ST_WAIT: begin
               if (done || tmo_cnt == TMO_LAST) begin
                  m_req_o     <= 1'b0;
                  tmo_cnt     <= '0;
                  rdata_q     <= (done && !m_we_o) ? m_rdata_i : '0;
                  if_rvalid_o <= (owner == OWN_I);
                  d_rvalid_o  <= (owner == OWN_D);
                  if_err_o    <= !done && (owner == OWN_I);
                  d_err_o     <= !done && (owner == OWN_D);
                  state       <= ST_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (state == ST_REQ && m_gnt_i) begin
                     m_req_o <= 1'b0;
                     state   <= ST_WAIT;
                  end
               end
            end
            ST_RESP: begin
               tmo_cnt <= '0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model plus a reactive memory.
module tb_mem_port_arbiter;

   localparam int unsigned STARVE = 4;
   localparam int unsigned TMO    = 64;

   logic        clk, rst;
   logic        if_req_i, if_gnt_o, if_rvalid_o, if_err_o;
   logic [31:0] if_addr_i, if_rdata_o;
   logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o, d_err_o;
   logic [3:0]  d_be_i;
   logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
   logic        m_req_o, m_we_o, m_gnt_i, m_rvalid_i;
   logic [3:0]  m_be_o;
   logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;

   mem_port_arbiter #(
      .AW(32), .DW(32), .STARVE_MAX(STARVE), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
      .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
      .m_req_o(m_req_o), .m_we_o(m_we_o), .m_be_o(m_be_o), .m_addr_o(m_addr_o),
      .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i),
      .m_rdata_i(m_rdata_i)
   );

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string name);
      nvec++;
      nerr++;
      $display("FAIL %s: got no event expected one within cycle budget (cycle %0d)", name, cyc);
   endtask

   // Memory behaviour knobs (written by stimulus only).
   int gnt_lat  = 0;
   int rv_lat   = 1;
   bit mem_dead = 0;
   int stray_req = 0;
   int stray_ack = 0;

   // Observations of the DUT for the literal checks.
   string       alog = "";
   string       glog = "";
   int          mreq_cnt = 0;
   int          rv_total = 0;
   logic [31:0] last_rdata = '0;
   logic        last_err = 1'b0;

   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : (a ^ 32'h5EED_0000);
   endfunction

   // Model: one live transaction at a time, identified by its grant cycle.
   bit          live = 0, own_d = 0, exp_i, exp_d, exp_mreq, to;
   int          t_g, gnt_cyc, comp_cyc, r_cyc, dcount = 0;
   logic        t_we;
   logic [3:0]  t_be;
   logic [31:0] t_addr, t_wdata, t_data;
   bit          rv_pend = 0, rsp_we;
   int          rv_cnt, g_wait = 0;
   logic [31:0] rsp_addr, cur;

   initial begin
      m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0;
      mem[32'h100] = 32'hDEAD_BEEF;
      mem[32'h200] = 32'hAAAA_AAAA;
      mem[32'h600] = 32'hCAFE_F00D;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_outputs", {if_gnt_o, d_gnt_o, m_req_o, if_rvalid_o, d_rvalid_o,
                                if_err_o, d_err_o}, 0);
            live = 0; dcount = 0; rv_pend = 0; g_wait = 0;
            m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
            stray_ack = stray_req;
            continue;
         end
         if (if_gnt_o) alog = {alog, "I"};
         if (d_gnt_o) alog = {alog, "D"};
         if (m_req_o) mreq_cnt++;
         if (if_rvalid_o || d_rvalid_o) rv_total++;
         if (if_rvalid_o) begin last_rdata = if_rdata_o; last_err = if_err_o; end
         if (d_rvalid_o) begin last_rdata = d_rdata_o; last_err = d_err_o; end

         exp_i = 0; exp_d = 0;
         if (!live) begin
            if (d_req_i && !(if_req_i && dcount >= STARVE)) exp_d = 1;
            else if (if_req_i) exp_i = 1;
         end
         chk("if_gnt", if_gnt_o, exp_i);
         chk("d_gnt", d_gnt_o, exp_d);

         exp_mreq = live && cyc > t_g && cyc <= t_g + TMO && (gnt_cyc < 0 || cyc <= gnt_cyc);
         chk("m_req", m_req_o, exp_mreq);
         if (exp_mreq) begin
            chk("m_addr", m_addr_o, t_addr);
            chk("m_we", m_we_o, t_we);
            if (own_d) begin
               chk("m_be", m_be_o, t_be);
               chk("m_wdata", m_wdata_o, t_wdata);
            end
         end

         r_cyc = (comp_cyc >= 0) ? comp_cyc + 1 : t_g + TMO + 1;
         chk("if_rvalid", if_rvalid_o, live && !own_d && cyc == r_cyc);
         chk("d_rvalid", d_rvalid_o, live && own_d && cyc == r_cyc);
         if (live && cyc == r_cyc) begin
            to = (comp_cyc < 0);
            chk("rdata", own_d ? d_rdata_o : if_rdata_o, to ? 32'h0 : t_data);
            chk("err", own_d ? d_err_o : if_err_o, to);
            live = 0;
         end

         if (exp_i || exp_d) begin
            live = 1; t_g = cyc; gnt_cyc = -1; comp_cyc = -1; own_d = exp_d;
            if (exp_d) begin
               t_we = d_we_i; t_be = d_be_i; t_addr = d_addr_i; t_wdata = d_wdata_i;
               t_data = d_we_i ? 32'h0 : rd(d_addr_i);
               dcount = if_req_i ? dcount + 1 : 0;
               glog = {glog, "D"};
            end else begin
               t_we = 1'b0; t_addr = if_addr_i; t_data = rd(if_addr_i);
               dcount = 0;
               glog = {glog, "I"};
            end
         end

         // Memory side, driven for the coming rising edge.
         m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
         if (stray_req != stray_ack) begin
            stray_ack = stray_req;
            m_rvalid_i = 1'b1; m_rdata_i = 32'h5A5A_5A5A;
         end else if (rv_pend) begin
            if (rv_cnt > 1) rv_cnt--;
            else begin
               rv_pend = 0;
               m_rvalid_i = 1'b1;
               m_rdata_i = rsp_we ? 32'hFFFF_FFFF : rd(rsp_addr);
               if (live && comp_cyc < 0 && cyc <= t_g + TMO) comp_cyc = cyc;
            end
         end else if (m_req_o && !mem_dead) begin
            if (g_wait < gnt_lat) g_wait++;
            else begin
               g_wait = 0;
               m_gnt_i = 1'b1;
               if (live) gnt_cyc = cyc;
               rsp_addr = m_addr_o; rsp_we = m_we_o;
               if (m_we_o) begin
                  cur = rd(m_addr_o);
                  for (int b = 0; b < 4; b++) if (m_be_o[b]) cur[8*b +: 8] = m_wdata_o[8*b +: 8];
                  mem[m_addr_o] = cur;
               end
               if (rv_lat == 0) begin
                  m_rvalid_i = 1'b1;
                  m_rdata_i = m_we_o ? 32'hFFFF_FFFF : rd(m_addr_o);
                  if (live && comp_cyc < 0) comp_cyc = cyc;
               end else begin
                  rv_pend = 1; rv_cnt = rv_lat;
               end
            end
         end
      end
   end

   task automatic start_req(input bit is_d, input bit we, input logic [3:0] be,
                            input logic [31:0] a, input logic [31:0] wd);
      @(posedge clk); #1;
      if (is_d) begin
         d_req_i = 1'b1; d_we_i = we; d_be_i = be; d_addr_i = a; d_wdata_i = wd;
      end else begin
         if_req_i = 1'b1; if_addr_i = a;
      end
   endtask

   task automatic wait_gnt(input bit is_d, output int tg);
      bit got = 0;
      tg = -1;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk); #1;
         if (is_d ? d_gnt_o : if_gnt_o) begin got = 1; tg = cyc; end
      end
      if (!got) bound_fail("grant_wait");
   endtask

   task automatic drop_req();
      @(posedge clk); #1;
      if_req_i = 1'b0; d_req_i = 1'b0;
   endtask

   task automatic wait_rv(input bit is_d, output int tr);
      bit got = 0;
      tr = -1;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk); #1;
         if (is_d ? d_rvalid_o : if_rvalid_o) begin got = 1; tr = cyc; end
      end
      if (!got) bound_fail("rvalid_wait");
   endtask

   int tg, tr, s0, r0, c0;

   initial begin
      rst = 1'b1;
      if_req_i = 1'b0; if_addr_i = '0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {m_req_o, if_rvalid_o, d_rvalid_o, if_err_o, d_err_o}, 0);
      chk("reset_addr", m_addr_o, 0);
      rst = 1'b0;

      // Fetch with zero-wait memory.
      start_req(0, 0, 4'h0, 32'h100, 32'h0);
      wait_gnt(0, tg); drop_req(); wait_rv(0, tr);
      chk("t1_latency", tr - tg, 3);
      chk("t1_rdata", last_rdata, 32'hDEAD_BEEF);
      chk("t1_err", last_err, 0);

      // Partial store held against a slow grant, then read back.
      gnt_lat = 3;
      start_req(1, 1, 4'b0011, 32'h200, 32'h0000_1234);
      wait_gnt(1, tg); drop_req();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         chk("t3_cmd", {m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o},
             {1'b1, 1'b1, 4'b0011, 32'h200, 32'h1234});
      end
      wait_rv(1, tr);
      chk("t3_store_rdata", last_rdata, 0);
      gnt_lat = 0;
      start_req(1, 0, 4'hF, 32'h200, 32'h0);
      wait_gnt(1, tg); drop_req(); wait_rv(1, tr);
      chk("t3_readback", last_rdata, 32'hAAAA_1234);

      // Both requesters held high: starvation guard interleaves fetch.
      s0 = alog.len();
      c0 = glog.len();
      @(posedge clk); #1;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300;
      if_req_i = 1'b1; if_addr_i = 32'h100;
      for (int k = 0; k < 400 && alog.len() < s0 + 10; k++) begin
         @(negedge clk); #1;
      end
      if (alog.len() < s0 + 10) bound_fail("t2_grants");
      drop_req();
      repeat (6) @(posedge clk);
      nvec++;
      if (alog.substr(s0, s0 + 9) != "DDDDIDDDDI") begin
         nerr++;
         $display("FAIL t2_order: got %s expected DDDDIDDDDI", alog.substr(s0, s0 + 9));
      end
      nvec++;
      if (glog.substr(c0, c0 + 9) != "DDDDIDDDDI") begin
         nerr++;
         $display("FAIL t2_model_order: got %s expected DDDDIDDDDI", glog.substr(c0, c0 + 9));
      end

      // Dead memory: timeout, a fetch that gives up early, then a stray late response.
      mem_dead = 1;
      r0 = mreq_cnt;
      start_req(1, 0, 4'hF, 32'h500, 32'h0);
      wait_gnt(1, tg); drop_req();
      repeat (5) @(posedge clk);
      #1; if_req_i = 1'b1; if_addr_i = 32'h100;
      repeat (3) @(posedge clk);
      #1; if_req_i = 1'b0;
      wait_rv(1, tr);
      chk("t4_latency", tr - tg, TMO + 1);
      chk("t4_mreq_cycles", mreq_cnt - r0, TMO);
      chk("t4_err", last_err, 1);
      chk("t4_rdata", last_rdata, 0);
      mem_dead = 0;
      r0 = rv_total;
      @(posedge clk); #1; stray_req++;
      repeat (5) @(posedge clk);
      chk("t4_stray_ignored", rv_total - r0, 0);

      // Grant and response in the same cycle.
      rv_lat = 0;
      r0 = rv_total;
      start_req(1, 0, 4'hF, 32'h600, 32'h0);
      wait_gnt(1, tg); drop_req(); wait_rv(1, tr);
      chk("t6_latency", tr - tg, 2);
      chk("t6_rdata", last_rdata, 32'hCAFE_F00D);
      repeat (5) @(posedge clk);
      chk("t6_single_pulse", rv_total - r0, 1);

      // Reset during WAIT, then a fetch granted in the first idle cycle.
      rv_lat = 20;
      start_req(0, 0, 4'h0, 32'h700, 32'h0);
      wait_gnt(0, tg); drop_req();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h100;
      #1;
      chk("t5_async_zero", {if_gnt_o, d_gnt_o, m_req_o, if_rvalid_o, d_rvalid_o}, 0);
      chk("t5_async_addr", m_addr_o, 0);
      rv_lat = 1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("t5_first_idle_gnt", if_gnt_o, 1);
      drop_req(); wait_rv(0, tr);
      chk("t5_rdata", last_rdata, 32'hDEAD_BEEF);

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

endmodule
